// File: rtl/three_bit_scan_sequencer_if.sv
// Select-code bus between a scan controller and the 3-to-8 decoder driver.
// The controller drives start/stop/one_shot. The sequencer returns the code and its status.
interface three_bit_scan_sequencer_if;
  logic start;
  logic stop;
  logic one_shot;
  logic x;
  logic y;
  logic z;
  logic sel_valid;
  logic busy;
  logic done;

  modport master (
    output start,
    output stop,
    output one_shot,
    input  x,
    input  y,
    input  z,
    input  sel_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    input  one_shot,
    output x,
    output y,
    output z,
    output sel_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/three_bit_scan_sequencer.sv
// Steps the decoder select code {x,y,z} through 0..7. Each code is held for DWELL clocks.
// An optional BLANK gap separates codes. The scan runs as a loop or as a single one-shot pass.
module three_bit_scan_sequencer #(
  parameter int DWELL = 50,
  parameter int BLANK = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  three_bit_scan_sequencer_if.slave   bus
);

  localparam int CNT_MAX_C = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW_C      = $clog2(CNT_MAX_C + 1);

  localparam logic [CW_C-1:0] CNT_ZERO_C   = CW_C'(0);
  localparam logic [CW_C-1:0] CNT_ONE_C    = CW_C'(1);
  localparam logic [CW_C-1:0] DWELL_LAST_C = CW_C'(DWELL - 1);
  localparam logic [CW_C-1:0] BLANK_LAST_C = CW_C'((BLANK > 0) ? (BLANK - 1) : 0);
  localparam logic            HAS_BLANK_C  = (BLANK > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2:0]      code_r;
  logic [2:0]      code_s;
  logic [CW_C-1:0] cnt_r;
  logic [CW_C-1:0] cnt_s;
  logic            mode_r;
  logic            mode_s;
  logic            done_s;
  logic            sel_valid_s;
  logic            busy_s;

  // State register: FSM state, current code, dwell/blank counter and captured mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      code_r  <= 3'd0;
      cnt_r   <= CNT_ZERO_C;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      code_r  <= code_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
    end
  end

  // Next-state logic: stop always wins, then dwell/blank terminal counts decide the step.
  always_comb begin
    state_s = state_r;
    code_s  = code_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        code_s = 3'd0;
        cnt_s  = CNT_ZERO_C;
        if (bus.start && !bus.stop) begin
          state_s = ST_SHOW;
          mode_s  = bus.one_shot;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
          code_s  = 3'd0;
          cnt_s   = CNT_ZERO_C;
        end else if (cnt_r == DWELL_LAST_C) begin
          cnt_s = CNT_ZERO_C;
          if ((code_r == 3'd7) && mode_r) begin
            // One-shot pass complete: no trailing blank, pulse done on return to idle.
            state_s = ST_IDLE;
            code_s  = 3'd0;
            done_s  = 1'b1;
          end else if (HAS_BLANK_C) begin
            state_s = ST_BLANK;
          end else begin
            state_s = ST_SHOW;
            code_s  = code_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE_C;
        end
      end
      ST_BLANK: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
          code_s  = 3'd0;
          cnt_s   = CNT_ZERO_C;
        end else if (cnt_r == BLANK_LAST_C) begin
          state_s = ST_SHOW;
          code_s  = code_r + 3'd1;
          cnt_s   = CNT_ZERO_C;
        end else begin
          cnt_s = cnt_r + CNT_ONE_C;
        end
      end
      default: begin
        state_s = ST_IDLE;
        code_s  = 3'd0;
        cnt_s   = CNT_ZERO_C;
        mode_s  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state register.
  always_comb begin
    sel_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_s)
      ST_SHOW: begin
        sel_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      ST_BLANK: begin
        sel_valid_s = 1'b0;
        busy_s      = 1'b1;
      end
      default: begin
        sel_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Output register: the decoder select lines and status flags are driven directly from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.x         <= 1'b0;
      bus.y         <= 1'b0;
      bus.z         <= 1'b0;
      bus.sel_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.x         <= code_s[2];
      bus.y         <= code_s[1];
      bus.z         <= code_s[0];
      bus.sel_valid <= sel_valid_s;
      bus.busy      <= busy_s;
      bus.done      <= done_s;
    end
  end

endmodule

// File: tb/tb_three_bit_scan_sequencer.sv
// Directed bench for three_bit_scan_sequencer: DUT a uses DWELL=4/BLANK=1, DUT b uses DWELL=2/BLANK=0.
// Outputs are packed as {done,busy,sel_valid,x,y,z} and sampled on the falling edge.
module tb_three_bit_scan_sequencer;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miscompares;

  three_bit_scan_sequencer_if bus_a ();
  three_bit_scan_sequencer_if bus_b ();

  three_bit_scan_sequencer #(.DWELL(4), .BLANK(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  three_bit_scan_sequencer #(.DWELL(2), .BLANK(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] obs_a();
    return {bus_a.done, bus_a.busy, bus_a.sel_valid, bus_a.x, bus_a.y, bus_a.z};
  endfunction

  function automatic logic [5:0] obs_b();
    return {bus_b.done, bus_b.busy, bus_b.sel_valid, bus_b.x, bus_b.y, bus_b.z};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (done,busy,sel_valid,x,y,z)", tag, obs, exp);
    end
  endtask

  // Expected DUT a outputs in cycle c after the start cycle (c=0), from the code k / phase timetable.
  function automatic logic [5:0] exp_a(input int c, input bit os, input int stop_at);
    int         k;
    int         ph;
    logic [2:0] kk;
    if (stop_at > 0 && c > stop_at) return 6'b000000;
    if (os && c == 40) return 6'b100000;
    if (os && c > 40) return 6'b000000;
    k  = ((c - 1) / 5) % 8;
    ph = (c - 1) % 5;
    kk = k[2:0];
    return {1'b0, 1'b1, (ph < 4) ? 1'b1 : 1'b0, kk};
  endfunction

  task automatic scan_a(input string name, input bit os, input int n, input int stop_at,
                        input int pulse1, input int pulse2);
    @(negedge clk);
    bus_a.start    = 1'b1;
    bus_a.one_shot = os;
    bus_a.stop     = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check_eq($sformatf("%s c%0d", name, c), obs_a(), exp_a(c, os, stop_at));
      bus_a.start    = (c == pulse1 || c == pulse2) ? 1'b1 : 1'b0;
      bus_a.one_shot = 1'b0;
      bus_a.stop     = (c == stop_at) ? 1'b1 : 1'b0;
    end
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
  endtask

  initial begin
    vec_cnt        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus_a.start    = 1'b0;
    bus_a.stop     = 1'b0;
    bus_a.one_shot = 1'b0;
    bus_b.start    = 1'b0;
    bus_b.stop     = 1'b0;
    bus_b.one_shot = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("reset_a", obs_a(), 6'b000000);
    check_eq("reset_b", obs_b(), 6'b000000);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_release_a", obs_a(), 6'b000000);
    check_eq("post_release_b", obs_b(), 6'b000000);

    // Test 1: async reset while code 3 is being shown.
    scan_a("t1", 1'b0, 17, -1, 0, 0);
    #2 rst = 1'b1;
    #1 check_eq("t1_async_rst", obs_a(), 6'b000000);
    @(negedge clk);
    check_eq("t1_rst_held", obs_a(), 6'b000000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("t1_idle_a%0d", i), obs_a(), 6'b000000);
      check_eq($sformatf("t1_idle_b%0d", i), obs_b(), 6'b000000);
    end

    // Test 2: full one-shot pass, done in cycle 40.
    scan_a("t2", 1'b1, 42, -1, 0, 0);

    // Test 5: start pulses mid-scan (one_shot low) must not disturb the pass.
    scan_a("t5", 1'b1, 42, -1, 7, 23);

    // Test 4: stop during the blank after code 5, then start+stop together in idle.
    scan_a("t4", 1'b1, 34, 30, 0, 0);
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.stop  = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_start_stop%0d", i), obs_a(), 6'b000000);
      @(negedge clk);
    end

    // Test 6: stop on code 7's final dwell cycle suppresses done.
    scan_a("t6", 1'b1, 42, 39, 0, 0);

    // Test 3: DUT b loops back-to-back with no blank gap and never pulses done.
    @(negedge clk);
    bus_b.start    = 1'b1;
    bus_b.one_shot = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      logic [2:0] kk;
      int         k;
      @(negedge clk);
      bus_b.start = 1'b0;
      k  = ((c - 1) / 2) % 8;
      kk = k[2:0];
      check_eq($sformatf("t3 c%0d", c), obs_b(), {3'b011, kk});
      bus_b.stop = (c == 40) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    bus_b.stop = 1'b0;
    check_eq("t3_stopped", obs_b(), 6'b000000);
    @(negedge clk);
    check_eq("t3_idle", obs_b(), 6'b000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
